pong_game_ctrl: RTL and testbench

Game-level sequencer for the pong datapath. It runs the match state machine (idle, serve, play, point pause, game over) and paces the serve and pause delays in video frames. It gates the ball and paddle movers, commands ball re-centring and serve direction, and keeps both scores. It sits beside the ball and paddle blocks on the divided pixel clock and consumes their event pulses.

---
 rtl/pong_pkg.sv | 25 ++
 rtl/frame_timer.sv | 33 +++
 rtl/pong_game_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
//==============================================================================
// Module  : pong_pkg
// Brief   : Shared types and constants for the pong game sequencer.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package pong_pkg;

  localparam int SCORE_W = 4;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } game_state_t;

endpackage : pong_pkg

`default_nettype wire

// File: rtl/frame_timer.sv
//==============================================================================
// Module  : frame_timer
// Brief   : 8-bit frame down-counter; flags expiry when a tick lands on count 1.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module frame_timer (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       tick_i,
  output logic       expire_o
);

  logic [7:0] count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= 8'd0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (tick_i && (count_q != 8'd0)) begin
      count_q <= count_q - 8'd1;
    end
  end

  assign expire_o = tick_i && (count_q == 8'd1);

endmodule : frame_timer

`default_nettype wire

// File: rtl/pong_game_ctrl.sv
//==============================================================================
// Module  : pong_game_ctrl
// Brief   : Match sequencer: serve/play/point/over FSM, scores, mover gating.
//           Optional ball speed-up on hit count when PONG_SPEEDUP_EN is defined.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90,
  parameter int unsigned WIN_SCORE    = 7
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               frame_tick_i,
  input  logic               start_i,
  input  logic               hit_i,
  input  logic               miss_left_i,
  input  logic               miss_right_i,
  output logic               ball_en_o,
  output logic               ball_load_o,
  output logic               serve_dir_o,
  output logic               paddle_en_o,
  output logic [SCORE_W-1:0] score_left_o,
  output logic [SCORE_W-1:0] score_right_o,
  output logic [2:0]         game_state_o,
  output logic               game_over_o,
  output logic               winner_o,
  output logic [1:0]         speed_level_o
);

  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [7:0]         SERVE_VAL = 8'(SERVE_FRAMES);
  localparam logic [7:0]         POINT_VAL = 8'(POINT_FRAMES);

  game_state_t        state_q;
  logic               start_q;
  logic               ball_en_q, paddle_en_q, ball_load_q, serve_dir_q;
  logic               game_over_q, winner_q;
  logic [SCORE_W-1:0] score_left_q, score_right_q;
  logic [SCORE_W-1:0] score_left_d, score_right_d;

  logic       start_edge, miss_any, left_wins, right_wins, point_win;
  logic       timer_load, timer_tick, timer_expire;
  logic [7:0] timer_val;

  assign start_edge    = start_i & ~start_q;
  assign miss_any      = miss_left_i | miss_right_i;
  assign score_left_d  = score_left_q + SCORE_W'(1);
  assign score_right_d = score_right_q + SCORE_W'(1);
  // A simultaneous double miss scores nobody, so it can never end the match.
  assign left_wins     = miss_right_i & ~miss_left_i & (score_left_d == WIN_VAL);
  assign right_wins    = miss_left_i & ~miss_right_i & (score_right_d == WIN_VAL);
  assign point_win     = left_wins | right_wins;
  assign timer_tick    = frame_tick_i & ((state_q == ST_SERVE) | (state_q == ST_POINT));

  always_comb begin
    timer_load = 1'b0;
    timer_val  = SERVE_VAL;
    case (state_q)
      ST_IDLE, ST_OVER: timer_load = start_edge;
      ST_PLAY: begin
        timer_load = miss_any & ~point_win;
        timer_val  = POINT_VAL;
      end
      ST_POINT: timer_load = timer_expire;
      default: timer_load = 1'b0;
    endcase
  end

  frame_timer u_frame_timer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .tick_i     (timer_tick),
    .expire_o   (timer_expire)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      start_q       <= 1'b1;
      ball_en_q     <= 1'b0;
      paddle_en_q   <= 1'b0;
      ball_load_q   <= 1'b0;
      serve_dir_q   <= DIR_RIGHT;
      score_left_q  <= '0;
      score_right_q <= '0;
      game_over_q   <= 1'b0;
      winner_q      <= 1'b0;
    end else begin
      start_q     <= start_i;
      ball_load_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start_edge) begin
            state_q       <= ST_SERVE;
            score_left_q  <= '0;
            score_right_q <= '0;
            serve_dir_q   <= DIR_RIGHT;
            winner_q      <= 1'b0;
            game_over_q   <= 1'b0;
            paddle_en_q   <= 1'b1;
            ball_en_q     <= 1'b0;
            ball_load_q   <= 1'b1;
          end
        end
        ST_SERVE: begin
          if (timer_expire) begin
            state_q   <= ST_PLAY;
            ball_en_q <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (miss_any) begin
            ball_en_q   <= 1'b0;
            paddle_en_q <= 1'b0;
            if (miss_left_i && !miss_right_i) begin
              score_right_q <= score_right_d;
              serve_dir_q   <= DIR_LEFT;
            end
            if (miss_right_i && !miss_left_i) begin
              score_left_q <= score_left_d;
              serve_dir_q  <= DIR_RIGHT;
            end
            if (point_win) begin
              state_q     <= ST_OVER;
              game_over_q <= 1'b1;
              winner_q    <= right_wins;
            end else begin
              state_q <= ST_POINT;
            end
          end
        end
        ST_POINT: begin
          if (timer_expire) begin
            state_q     <= ST_SERVE;
            paddle_en_q <= 1'b1;
            ball_load_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          ball_en_q   <= 1'b0;
          paddle_en_q <= 1'b0;
          game_over_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef PONG_SPEEDUP_EN
  logic [1:0] hit_cnt_q, speed_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || ball_load_q) begin
      hit_cnt_q <= 2'd0;
      speed_q   <= 2'd0;
    end else if (hit_i && (state_q == ST_PLAY)) begin
      hit_cnt_q <= hit_cnt_q + 2'd1;
      if ((hit_cnt_q == 2'd3) && (speed_q != 2'd3)) begin
        speed_q <= speed_q + 2'd1;
      end
    end
  end

  assign speed_level_o = speed_q;
`else
  logic unused_hit;
  assign unused_hit    = hit_i;
  assign speed_level_o = 2'd0;
`endif

  assign ball_en_o     = ball_en_q;
  assign ball_load_o   = ball_load_q;
  assign serve_dir_o   = serve_dir_q;
  assign paddle_en_o   = paddle_en_q;
  assign score_left_o  = score_left_q;
  assign score_right_o = score_right_q;
  assign game_state_o  = state_q;
  assign game_over_o   = game_over_q;
  assign winner_o      = winner_q;

endmodule : pong_game_ctrl

`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
//==============================================================================
// Module  : tb_pong_game_ctrl
// Brief   : Scoreboard bench for pong_game_ctrl with a rule-level match model.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pong_game_ctrl;

  localparam int SERVE_F = 2;
  localparam int POINT_F = 3;
  localparam int WIN     = 3;

  logic clk = 1'b0;
  logic reset, frame_tick, start, hit, miss_left, miss_right;
  logic ball_en, ball_load, serve_dir, paddle_en, game_over, winner;
  logic [3:0] score_left, score_right;
  logic [2:0] game_state;
  logic [1:0] speed_level;

  always #5 clk = ~clk;

  pong_game_ctrl #(.SERVE_FRAMES(SERVE_F), .POINT_FRAMES(POINT_F), .WIN_SCORE(WIN)) dut (
    .clk_i(clk), .reset_i(reset), .frame_tick_i(frame_tick), .start_i(start),
    .hit_i(hit), .miss_left_i(miss_left), .miss_right_i(miss_right),
    .ball_en_o(ball_en), .ball_load_o(ball_load), .serve_dir_o(serve_dir),
    .paddle_en_o(paddle_en), .score_left_o(score_left), .score_right_o(score_right),
    .game_state_o(game_state), .game_over_o(game_over), .winner_o(winner),
    .speed_level_o(speed_level)
  );

  typedef struct packed {
    logic       ball_en, paddle_en, ball_load, serve_dir;
    logic [3:0] sl, sr;
    logic [2:0] st;
    logic       over, win;
    logic [1:0] spd;
  } out_t;

  out_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   cur_start;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Match model: phases 0 idle, 1 serve, 2 play, 3 point, 4 over.
  int phase, ticks, sl, sr, hits, speed;
  bit dir, win_side, load_out, start_prev;

  task automatic model_step(input bit r, st, tk, h, ml, mr);
    bit edge_start;
    bit load_now;
    load_now = 1'b0;
    if (r) begin
      phase = 0; ticks = 0; sl = 0; sr = 0; hits = 0; speed = 0;
      dir = 1'b1; win_side = 1'b0; load_out = 1'b0; start_prev = 1'b1;
      return;
    end
    edge_start = st && !start_prev;
    start_prev = st;
    if (load_out) begin
      hits = 0;
      speed = 0;
    end
    case (phase)
      0, 4: if (edge_start) begin
        sl = 0; sr = 0; dir = 1'b1; win_side = 1'b0; ticks = 0;
        phase = 1; load_now = 1'b1;
      end
      1: if (tk) begin
        ticks++;
        if (ticks == SERVE_F) phase = 2;
      end
      2: begin
`ifdef PONG_SPEEDUP_EN
        if (h) begin
          hits++;
          if ((hits % 4 == 0) && (speed < 3)) speed++;
        end
`endif
        if (ml || mr) begin
          if (ml && !mr) begin sr++; dir = 1'b0; end
          if (mr && !ml) begin sl++; dir = 1'b1; end
          if (sl == WIN) begin phase = 4; win_side = 1'b0; end
          else if (sr == WIN) begin phase = 4; win_side = 1'b1; end
          else begin phase = 3; ticks = 0; end
        end
      end
      3: if (tk) begin
        ticks++;
        if (ticks == POINT_F) begin phase = 1; ticks = 0; load_now = 1'b1; end
      end
      default: phase = 0;
    endcase
    load_out = load_now;
  endtask

  function automatic out_t model_out();
    out_t o;
    o.ball_en   = (phase == 2);
    o.paddle_en = (phase == 1) || (phase == 2);
    o.ball_load = load_out;
    o.serve_dir = dir;
    o.sl        = 4'(sl);
    o.sr        = 4'(sr);
    o.st        = 3'(phase);
    o.over      = (phase == 4);
    o.win       = win_side;
    o.spd       = 2'(speed);
    return o;
  endfunction

  // Monitor: one expected snapshot per clock, consumed on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        out_t e;
        e = sb.pop_front();
        check("ball_en",     int'(ball_en),     int'(e.ball_en));
        check("paddle_en",   int'(paddle_en),   int'(e.paddle_en));
        check("ball_load",   int'(ball_load),   int'(e.ball_load));
        check("serve_dir",   int'(serve_dir),   int'(e.serve_dir));
        check("score_left",  int'(score_left),  int'(e.sl));
        check("score_right", int'(score_right), int'(e.sr));
        check("game_state",  int'(game_state),  int'(e.st));
        check("game_over",   int'(game_over),   int'(e.over));
        check("winner",      int'(winner),      int'(e.win));
        check("speed_level", int'(speed_level), int'(e.spd));
      end
    end
  end

  task automatic step(input bit r, st, tk, h, ml, mr);
    reset = r; start = st; frame_tick = tk; hit = h; miss_left = ml; miss_right = mr;
    model_step(r, st, tk, h, ml, mr);
    sb.push_back(model_out());
    @(negedge clk);
    #1;
  endtask

  task automatic cyc(input bit tk, h, ml, mr);
    step(1'b0, cur_start, tk, h, ml, mr);
  endtask

  task automatic ticks_n(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; frame_tick = 1'b0; hit = 1'b0;
    miss_left = 1'b0; miss_right = 1'b0;
    @(negedge clk);
    #1;

    cur_start = 1'b1;
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_state", int'(game_state), 0);
    check("reset_serve_dir", int'(serve_dir), 1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("held_start_idle", int'(game_state), 0);

    cur_start = 1'b0; cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cur_start = 1'b1; cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("start_serve", int'(game_state), 1);
    check("start_load", int'(ball_load), 1);
    cur_start = 1'b0; cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("load_one_cycle", int'(ball_load), 0);

    ticks_n(SERVE_F);
    check("play_ball_en", int'(ball_en), 1);

    repeat (9) cyc(1'b0, 1'b1, 1'b0, 1'b0);
`ifdef PONG_SPEEDUP_EN
    check("speed_9_hits", int'(speed_level), 2);
`else
    check("speed_9_hits", int'(speed_level), 0);
`endif
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("miss_left_score_r", int'(score_right), 1);
    check("miss_left_dir", int'(serve_dir), 0);
    ticks_n(POINT_F);
    check("reserve_speed_clr", int'(speed_level), 0);

    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("serve_miss_ignored", int'(score_right), 1);
    ticks_n(SERVE_F);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check("double_miss_state", int'(game_state), 3);
    check("double_miss_dir", int'(serve_dir), 0);
    ticks_n(POINT_F);
    ticks_n(SERVE_F);

    for (int p = 0; p < WIN; p++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      if (p < WIN - 1) begin
        ticks_n(POINT_F);
        ticks_n(SERVE_F);
      end
    end
    check("over_score_left", int'(score_left), WIN);
    check("over_winner", int'(winner), 0);
    check("over_flag", int'(game_over), 1);

    cur_start = 1'b1; cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("restart_score_l", int'(score_left), 0);
    check("restart_state", int'(game_state), 1);
    cur_start = 1'b0; cyc(1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      bit r;
      if ($urandom_range(0, 15) == 0) cur_start = ~cur_start;
      r = ($urandom_range(0, 399) == 0);
      step(r, cur_start, ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

    for (int w = 0; w < 4 && sb.size() > 0; w++) @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_pong_game_ctrl

`default_nettype wire
